// File: rtl/grid_clb_param.sv
// grid_clb_param
// Parametrised configurable logic block tile. It holds NUM_OUTPUTS basic
// logic elements (BLEs). Each BLE has a LUT_K-input LUT, one select mux per
// LUT input and an optional output flip-flop. All BLEs are programmed through
// one serial configuration chain. The chain passes from tile to tile through
// ccff_head and ccff_tail.
//
// Ports
//   clk          single clock; all state changes on its rising edge
//   reset        synchronous, active-high; clears config, counter and FFs
//   prog_en      shift one configuration bit per cycle while high
//   prog_restart clears the bit counter and cfg_done; config bits untouched
//   ccff_head    serial configuration data in
//   ce           clock enable for the user flip-flops
//   clb_I        tile input pins
//   clb_O        BLE outputs, forced to 0 until configuration is complete
//   ccff_tail    serial configuration data out (top bit of the chain)
//   cfg_done     high once exactly CFG_BITS bits are loaded and prog_en is low
module grid_clb_param #(
  parameter int NUM_INPUTS  = 10,
  parameter int NUM_OUTPUTS = 4,
  parameter int LUT_K       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prog_en,
  input  logic                   prog_restart,
  input  logic                   ccff_head,
  input  logic                   ce,
  input  logic [NUM_INPUTS-1:0]  clb_I,
  output logic [NUM_OUTPUTS-1:0] clb_O,
  output logic                   ccff_tail,
  output logic                   cfg_done
);

  localparam int SRC_W      = NUM_INPUTS + NUM_OUTPUTS;
  localparam int SEL_W      = $clog2(SRC_W);
  localparam int TABLE_BITS = 2 ** LUT_K;
  localparam int BLE_BITS   = TABLE_BITS + LUT_K * SEL_W + 1;
  localparam int CFG_BITS   = NUM_OUTPUTS * BLE_BITS;
  localparam int CNT_W      = $clog2(CFG_BITS + 1);

  logic [CFG_BITS-1:0]    cfg;
  logic [CNT_W-1:0]       count_q;
  logic [NUM_OUTPUTS-1:0] ff_q;
  logic [NUM_OUTPUTS-1:0] lut_out;

  // Evaluate one BLE from its configuration slice.
  // The source vector is {ff_q, clb_I}. Feedback therefore always comes from
  // registers, so no combinational loop can form. A select value past the end
  // of the source vector reads as constant 0.
  function automatic logic ble_eval(input logic [BLE_BITS-1:0] slice,
                                    input logic [SRC_W-1:0]    src);
    logic [LUT_K-1:0]      idx;
    logic [SEL_W-1:0]      sel;
    logic [TABLE_BITS-1:0] table_bits;
    idx        = '0;
    table_bits = slice[TABLE_BITS-1:0];
    for (int i = 0; i < LUT_K; i++) begin
      sel = slice[TABLE_BITS + i*SEL_W +: SEL_W];
      if (int'(sel) < SRC_W) idx[i] = src[sel];
    end
    return table_bits[idx];
  endfunction

  // Configuration shift register.
  // A new bit enters at the bottom. The top bit is the serial output to the
  // next tile. Bits shifted beyond the chain length are lost.
  always_ff @(posedge clk) begin
    if (reset)
      cfg <= '0;
    else if (prog_en)
      cfg <= {cfg[CFG_BITS-2:0], ccff_head};
  end

  // Bit counter.
  // It saturates at the chain length. A restart wins over a simultaneous
  // shift: the bit still shifts in, but the count starts again from zero.
  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else if (prog_restart)
      count_q <= '0;
    else if (prog_en && (count_q != CNT_W'(CFG_BITS)))
      count_q <= count_q + 1'b1;
  end

  assign cfg_done  = (count_q == CNT_W'(CFG_BITS)) && !prog_en;
  assign ccff_tail = cfg[CFG_BITS-1];

  // LUT outputs for every BLE.
  // These are evaluated all the time. Gating by cfg_done happens at the
  // flip-flops and at the output pins.
  always_comb begin
    lut_out = '0;
    for (int j = 0; j < NUM_OUTPUTS; j++)
      lut_out[j] = ble_eval(cfg[j*BLE_BITS +: BLE_BITS], {ff_q, clb_I});
  end

  // User flip-flops.
  // They capture only when the tile is fully configured. During partial
  // programming and reprogramming they keep their old values.
  always_ff @(posedge clk) begin
    if (reset)
      ff_q <= '0;
    else if (ce && cfg_done)
      ff_q <= lut_out;
  end

  // Output pins.
  // The top bit of each BLE slice, reg_mode, picks the registered or the
  // combinational output. Everything reads 0 until configuration is done.
  always_comb begin
    clb_O = '0;
    for (int j = 0; j < NUM_OUTPUTS; j++)
      if (cfg_done)
        clb_O[j] = cfg[j*BLE_BITS + BLE_BITS - 1] ? ff_q[j] : lut_out[j];
  end

endmodule

// File: tb/tb_grid_clb_param.sv
// tb_grid_clb_param
// Self-checking bench for grid_clb_param with default parameters
// (10 inputs, 4 BLEs, 4-input LUTs, 132 configuration bits).
// A behavioural model holds the chain as a plain bit array, the counter as an
// integer and the flip-flops as bits. Each BLE is evaluated from the decode
// rules with integer arithmetic.
module tb_grid_clb_param;

  localparam int NI = 10;
  localparam int NO = 4;
  localparam int K  = 4;
  localparam int SW = 4;
  localparam int TT = 16;
  localparam int BB = 33;
  localparam int CB = 132;

  logic          clk = 1'b0;
  logic          reset, prog_en, prog_restart, ccff_head, ce;
  logic [NI-1:0] clb_I;
  logic [NO-1:0] clb_O;
  logic          ccff_tail, cfg_done;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  grid_clb_param #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .LUT_K(K)) dut (
    .clk(clk), .reset(reset), .prog_en(prog_en), .prog_restart(prog_restart),
    .ccff_head(ccff_head), .ce(ce), .clb_I(clb_I), .clb_O(clb_O),
    .ccff_tail(ccff_tail), .cfg_done(cfg_done)
  );

  bit m_cfg[CB];
  int m_cnt;
  bit m_ff[NO];

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 0;

  logic [NO-1:0] obsO;
  logic          obsDone, obsTail;

  // Count one comparison and report it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference evaluation of BLE j.
  // Each select field is read as an integer. The source is a pin, a feedback
  // FF or zero. The truth table is then indexed with the input bits weighted
  // by powers of two.
  function automatic bit modelLut(input int j, input logic [NI-1:0] pins);
    int idx;
    int s;
    bit v;
    idx = 0;
    for (int i = 0; i < K; i++) begin
      s = 0;
      for (int b = 0; b < SW; b++)
        if (m_cfg[j*BB + TT + i*SW + b]) s += (1 << b);
      if (s < NI)           v = pins[s];
      else if (s < NI + NO) v = m_ff[s - NI];
      else                  v = 1'b0;
      if (v) idx += (1 << i);
    end
    return m_cfg[j*BB + idx];
  endfunction

  // Build one BLE configuration word: {reg_mode, sel3..sel0, table}.
  function automatic logic [BB-1:0] mkBle(input logic [15:0] t,
                                          input logic [3:0] s0, input logic [3:0] s1,
                                          input logic [3:0] s2, input logic [3:0] s3,
                                          input logic rm);
    return {rm, s3, s2, s1, s0, t};
  endfunction

  // Run one clock cycle.
  // Inputs are driven after the falling edge. The outputs are sampled and
  // compared against the model before the rising edge. The model then
  // advances once the edge has passed.
  task automatic applyStimulus(input bit r, input bit pe, input bit pr,
                               input bit h, input bit c, input logic [NI-1:0] pins);
    logic [NO-1:0] expO;
    bit            expDone, expTail;
    bit            lutv[NO];
    @(negedge clk);
    reset = r; prog_en = pe; prog_restart = pr; ccff_head = h; ce = c; clb_I = pins;
    #1;
    expDone = (m_cnt == CB) && !pe;
    expTail = m_cfg[CB-1];
    expO    = '0;
    for (int j = 0; j < NO; j++) begin
      lutv[j] = modelLut(j, pins);
      if (expDone) expO[j] = m_cfg[j*BB + BB - 1] ? m_ff[j] : lutv[j];
    end
    obsO = clb_O; obsDone = cfg_done; obsTail = ccff_tail;
    if (checkEn) begin
      checkOutput("clb_O", 32'(clb_O), 32'(expO));
      checkOutput("cfg_done", 32'(cfg_done), 32'(expDone));
      checkOutput("ccff_tail", 32'(ccff_tail), 32'(expTail));
    end
    @(posedge clk);
    if (r) begin
      for (int p = 0; p < CB; p++) m_cfg[p] = 1'b0;
      for (int j = 0; j < NO; j++) m_ff[j] = 1'b0;
      m_cnt = 0;
    end else begin
      if (pe) begin
        for (int p = CB-1; p > 0; p--) m_cfg[p] = m_cfg[p-1];
        m_cfg[0] = h;
      end
      if (pr)                  m_cnt = 0;
      else if (pe && m_cnt < CB) m_cnt = m_cnt + 1;
      if (c && expDone)
        for (int j = 0; j < NO; j++) m_ff[j] = lutv[j];
    end
  endtask

  // Shift a full configuration in, top bit first, with random pins and ce.
  task automatic loadConfig(input logic [CB-1:0] c);
    for (int k = CB-1; k >= 0; k--)
      applyStimulus(0, 1, 0, c[k], 1'($urandom), NI'($urandom));
  endtask

  task automatic idle(input bit c, input logic [NI-1:0] pins);
    applyStimulus(0, 0, 0, 0, c, pins);
  endtask

  logic [CB-1:0] cfgA;
  logic [CB-1:0] cfgR;
  bit            sent[CB];
  logic [7:0]    pat;

  initial begin
    for (int p = 0; p < CB; p++) m_cfg[p] = 1'b0;
    for (int j = 0; j < NO; j++) m_ff[j] = 1'b0;
    m_cnt = 0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, '0);
    checkEn = 1;
    applyStimulus(1, 0, 0, 0, 0, '0);
    checkOutput("rst_clbO", 32'(obsO), 0);
    checkOutput("rst_done", 32'(obsDone), 0);
    checkOutput("rst_tail", 32'(obsTail), 0);

    // 131 bits is one short of a full load
    for (int k = 0; k < CB-1; k++) applyStimulus(0, 1, 0, 1'($urandom), 1, NI'($urandom));
    idle(1, NI'($urandom));
    checkOutput("partial_done", 32'(obsDone), 0);
    checkOutput("partial_clbO", 32'(obsO), 0);

    // Chain pass-through with the 0xA5 pattern
    applyStimulus(1, 0, 0, 0, 0, '0);
    pat = 8'hA5;
    for (int k = 0; k < CB; k++) begin
      sent[k] = pat[7 - (k % 8)];
      applyStimulus(0, 1, 0, sent[k], 0, NI'($urandom));
    end
    idle(0, '0);
    checkOutput("pass_done", 32'(obsDone), 1);
    for (int k = 0; k < CB; k++) begin
      applyStimulus(0, 1, 0, 0, 0, NI'($urandom));
      checkOutput("pass_tail", 32'(obsTail), 32'(sent[k]));
    end
    idle(0, '0);
    checkOutput("sat_done", 32'(obsDone), 1);

    // AND4, feedback toggle, constant-1 through out-of-range selects,
    // registered XOR
    applyStimulus(1, 0, 0, 0, 0, '0);
    cfgA = {mkBle(16'h6996, 4, 5, 6, 7, 1), mkBle(16'h0001, 15, 15, 15, 15, 0),
            mkBle(16'h5555, 11, 15, 15, 15, 1), mkBle(16'h8000, 0, 1, 2, 3, 0)};
    loadConfig(cfgA);
    for (int k = 0; k < 4; k++) begin
      idle(1, NI'($urandom));
      checkOutput("toggle", 32'(obsO[1]), 32'(k % 2));
    end
    for (int k = 0; k < 2; k++) begin
      idle(0, NI'($urandom));
      checkOutput("ce_hold", 32'(obsO[1]), 0);
    end
    idle(0, 10'h00F);
    checkOutput("and4_F", 32'(obsO[0]), 1);
    idle(0, 10'h00E);
    checkOutput("and4_E", 32'(obsO[0]), 0);
    for (int k = 0; k < 4; k++) begin
      idle(1, NI'($urandom));
      checkOutput("oor_const1", 32'(obsO[2]), 1);
    end

    // Restart mid-operation, then reload; the FFs keep their state
    applyStimulus(0, 0, 1, 0, 1, NI'($urandom));
    idle(1, 10'h00F);
    checkOutput("restart_done", 32'(obsDone), 0);
    checkOutput("restart_clbO", 32'(obsO), 0);
    loadConfig(cfgA);
    for (int k = 0; k < 6; k++) idle(1'($urandom), NI'($urandom));

    // Reset during a load, at bit 60
    for (int k = 0; k < 60; k++) applyStimulus(0, 1, 0, 1, 1, NI'($urandom));
    applyStimulus(1, 1, 0, 1, 1, NI'($urandom));
    idle(1, NI'($urandom));
    checkOutput("rst60_done", 32'(obsDone), 0);
    checkOutput("rst60_tail", 32'(obsTail), 0);
    for (int k = 0; k < CB-1; k++) applyStimulus(0, 1, 0, 0, 1, NI'($urandom));
    idle(1, NI'($urandom));
    checkOutput("rst60_cnt", 32'(obsDone), 0);

    // Restart and prog_en together leave the count at zero
    for (int k = 0; k < 100; k++) applyStimulus(0, 1, 0, 1'($urandom), 0, NI'($urandom));
    applyStimulus(0, 1, 1, 1'($urandom), 0, NI'($urandom));
    for (int k = 0; k < CB-1; k++) applyStimulus(0, 1, 0, 1'($urandom), 0, NI'($urandom));
    idle(0, '0);
    checkOutput("both_131", 32'(obsDone), 0);
    applyStimulus(0, 1, 0, 1'($urandom), 0, NI'($urandom));
    idle(0, '0);
    checkOutput("both_132", 32'(obsDone), 1);

    // Random configurations with random pins, ce and occasional restarts
    for (int n = 0; n < 6; n++) begin
      for (int w = 0; w < CB; w += 32) begin
        cfgR[w +: 32] = 32'($urandom);
      end
      loadConfig(cfgR);
      for (int k = 0; k < 60; k++)
        applyStimulus(0, ($urandom_range(0, 29) == 0), ($urandom_range(0, 39) == 0),
                      1'($urandom), 1'($urandom), NI'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
